// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store memory access unit.
// Width codes follow the RV32I funct3 encoding.
package mem_access_unit_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mau_state_t;

  // Undefined width codes count as misaligned so they never reach the bus
  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      MEM_B, MEM_BU: ok = 1'b1;
      MEM_H, MEM_HU: ok = ~lo[0];
      MEM_W:         ok = (lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] be_of(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      MEM_B, MEM_BU: be = 4'b0001 << lo;
      MEM_H, MEM_HU: be = 4'b0011 << lo;
      MEM_W:         be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic data_t wdata_of(
    input logic [2:0] f3,
    input data_t      wd
  );
    data_t r;
    r = wd;
    case (f3)
      MEM_B:   r = {4{wd[7:0]}};
      MEM_H:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data lane select and sign/zero extension.
// Purely combinational; driven from the held address and width.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  data_t       mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output data_t       result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = mem_rdata[7:0];
    unique case (addr_lo)
      2'd0: b = mem_rdata[7:0];
      2'd1: b = mem_rdata[15:8];
      2'd2: b = mem_rdata[23:16];
      2'd3: b = mem_rdata[31:24];
      default: b = mem_rdata[7:0];
    endcase
    h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    result = mem_rdata;
    case (funct3)
      MEM_B:   result = {{24{b[7]}}, b};
      MEM_H:   result = {{16{h[15]}}, h};
      MEM_BU:  result = {24'h0, b};
      MEM_HU:  result = {16'h0, h};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store port between the control FSM and a handshaked memory bus.
// One request in flight; misaligned and timed-out accesses still respond.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misaligned,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mau_state_t        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        lo_q, lo_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic              req_q, req_d;
  logic              mwe_q, mwe_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  data_t             wd_q, wd_d;
  data_t             rd_q, rd_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  data_t             ext;

  load_extend u_ext (
    .mem_rdata (mem_rdata),
    .addr_lo   (lo_q),
    .funct3    (f3_q),
    .result    (ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    we_d    = we_q;
    req_d   = req_q;
    mwe_d   = mwe_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          lo_d  = req_addr[1:0];
          f3_d  = req_funct3;
          we_d  = req_write;
          cnt_d = 8'd0;
          if (is_aligned(req_funct3, req_addr[1:0])) begin
            state_d = ACCESS;
            req_d   = 1'b1;
            mwe_d   = req_write;
            be_d    = be_of(req_funct3, req_addr[1:0]);
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wd_d    = req_write ?
                      wdata_of(req_funct3, req_wdata) :
                      32'h0;
          end else begin
            state_d = DONE;
            mis_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        // ack beats a simultaneous timeout
        if (mem_ack || cnt_q == TO_LAST) begin
          state_d = DONE;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          mwe_d   = 1'b0;
          be_d    = 4'b0000;
          addr_d  = '0;
          wd_d    = 32'h0;
          berr_d  = ~mem_ack;
          if (mem_ack && !we_q) rd_d = ext;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      lo_q    <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_rdata  = rd_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;
  assign mem_req    = req_q;
  assign mem_we     = mwe_q;
  assign mem_be     = be_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit.
// Bus responder is driven inline by the transaction task.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
    logic        berr;
  } rsp_t;

  rsp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] last_rd = 32'h0;

  mem_access_unit #(
    .TIMEOUT_CYCLES (4),
    .ADDR_W         (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic txn(input string       tag,
                     input logic        we,
                     input logic [2:0]  f3,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic [31:0] bus,
                     input int          ack_at,
                     input logic        emis,
                     input logic [3:0]  ebe,
                     input logic [31:0] ewd,
                     input logic [31:0] erd);
    rsp_t e;
    rsp_t g;
    logic berr;
    int   ncyc;
    int   k;
    berr = !emis && (ack_at < 1 || ack_at > 4);
    ncyc = emis ? 0 : (berr ? 4 : ack_at);
    e.rd   = (!we && !emis && !berr) ? erd : last_rd;
    e.mis  = emis;
    e.berr = berr;
    last_rd = e.rd;
    sb.push_back(e);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = ~we;
    req_funct3 = 3'b011;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    check({tag, ".busy"}, 32'(req_ready), 32'd0);
    if (!emis) begin
      check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tag, ".be"}, 32'(mem_be), 32'(ebe));
      check({tag, ".we"}, 32'(mem_we), 32'(we));
      if (we) check({tag, ".wdata"}, mem_wdata, ewd);
    end
    for (k = 0; k < 20 && mem_req; k++) begin
      if (k + 1 == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = bus;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    check({tag, ".reqcyc"}, 32'(k), 32'(ncyc));
    check({tag, ".rsp"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid && sb.size() > 0) begin
      g = sb.pop_front();
      check({tag, ".rdata"}, rsp_rdata, g.rd);
      check({tag, ".mis"}, 32'(misaligned), 32'(g.mis));
      check({tag, ".berr"}, 32'(bus_error), 32'(g.berr));
    end
    @(negedge clk);
    check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.rsp", 32'(rsp_valid), 32'd0);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.we", 32'(mem_we), 32'd0);
    check("rst.be", 32'(mem_be), 32'd0);
    check("rst.addr", mem_addr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.mis", 32'(misaligned), 32'd0);
    check("rst.berr", 32'(bus_error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    txn("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 3,
        0, 4'b1111, 32'hDEADBEEF, 0);
    txn("lb3", 0, 3'b000, 32'h203, 0, 32'h80FF7F01, 1,
        0, 4'b1000, 0, 32'hFFFFFF80);
    txn("lbu3", 0, 3'b100, 32'h203, 0, 32'h80FF7F01, 2,
        0, 4'b1000, 0, 32'h00000080);
    txn("lb1", 0, 3'b000, 32'h201, 0, 32'h80FF7F01, 1,
        0, 4'b0010, 0, 32'h0000007F);
    txn("sh", 1, 3'b001, 32'h32, 32'h1234ABCD, 0, 2,
        0, 4'b1100, 32'hABCDABCD, 0);
    txn("lh", 0, 3'b001, 32'h32, 0, 32'h80015555, 1,
        0, 4'b1100, 0, 32'hFFFF8001);
    txn("lhu", 0, 3'b101, 32'h32, 0, 32'h80015555, 3,
        0, 4'b1100, 0, 32'h00008001);
    txn("lw", 0, 3'b010, 32'h104, 0, 32'h12345678, 1,
        0, 4'b1111, 0, 32'h12345678);
    txn("lw_mis", 0, 3'b010, 32'h102, 0, 0, 0,
        1, 4'b0000, 0, 0);
    txn("sh_mis", 1, 3'b001, 32'h101, 32'h5555, 0, 0,
        1, 4'b0000, 0, 0);
    txn("f3_011", 0, 3'b011, 32'h100, 0, 0, 0,
        1, 4'b0000, 0, 0);
    txn("tmo", 0, 3'b010, 32'h200, 0, 0, 0,
        0, 4'b1111, 0, 0);
    txn("ack4", 0, 3'b010, 32'h204, 0, 32'hCAFEF00D, 4,
        0, 4'b1111, 0, 32'hCAFEF00D);
    txn("sb", 1, 3'b000, 32'h7, 32'h0000005A, 0, 1,
        0, 4'b1000, 32'h5A5A5A5A, 0);

    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid.req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid.req0", 32'(mem_req), 32'd0);
    check("mid.ready", 32'(req_ready), 32'd1);
    check("mid.rsp", 32'(rsp_valid), 32'd0);
    last_rd = 32'h0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late.rsp", 32'(rsp_valid), 32'd0);
    check("late.req", 32'(mem_req), 32'd0);
    check("late.rdata", rsp_rdata, 32'h0);
    txn("post", 0, 3'b010, 32'h44, 0, 32'h0BADF00D, 1,
        0, 4'b1111, 0, 32'h0BADF00D);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store memory port between the multicycle control FSM and a handshaked memory bus.
- Accepts one instruction-fetch, load or store request at a time.
- For stores: generates byte enables and lane-shifts the write data. For loads: extracts and sign- or zero-extends the read data.
- Detects misaligned accesses and bus timeouts; the control FSM waits on req_ready/rsp_valid instead of assuming single-cycle memory.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting with bus_error (8-bit counter, legal 1..255)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock, all state changes on posedge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request strobe from control FSM
- req_write  in  1  1=store, 0=load/fetch
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (fetch uses 010)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, unshifted (rs2)
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- rsp_valid  out  1  one-cycle pulse, transaction complete
- rsp_rdata  out  32  extended load data, valid with rsp_valid
- misaligned  out  1  valid with rsp_valid; access was not performed
- bus_error  out  1  valid with rsp_valid; mem_ack timeout
- mem_req  out  1  bus request, held high until mem_ack
- mem_we  out  1  bus write
- mem_be  out  4  byte enables (bit i = byte lane i)
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_ack  in  1  bus completion
- mem_rdata  in  32  bus read word, valid with mem_ack

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; req_ready=1; rsp_valid=0; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; rsp_rdata=0; misaligned=0; bus_error=0; timeout counter=0. Reset mid-transaction drops mem_req on the next edge; no response is issued.
- States:
  - IDLE -> ACCESS on accept when the access is aligned.
  - IDLE -> DONE on accept when misaligned.
  - ACCESS -> DONE on mem_ack, or when the counter reaches TIMEOUT_CYCLES.
  - DONE -> IDLE unconditionally.
- Accept captures addr, funct3, write, wdata into holding registers. Later changes to req_* are ignored until the next accept.
- Alignment:
  - H/HU require addr[0]==0.
  - W requires addr[1:0]==00.
  - B/BU are always aligned.
  - Undefined funct3 (011, 110, 111) is treated as misaligned.
- mem_be:
  - B: 0001<<addr[1:0]
  - H: 0011<<addr[1:0]
  - W: 1111
  - Loads also drive mem_be.
- mem_wdata:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata
- Load extract: byte/half is selected from mem_rdata by addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU, word passes through. rsp_rdata is registered at mem_ack and held until the next accepted load. Stores leave rsp_rdata unchanged.
- Timing:
  - Accept at edge N.
  - mem_req=1 from N until the edge where mem_ack=1 is sampled (edge M>=N+1).
  - rsp_valid=1 for the cycle after M.
  - Minimum total latency: 2 cycles from accept to rsp_valid.
- mem_req/mem_we/mem_be/mem_addr/mem_wdata are registered and stable while mem_req=1. They go to zero when not in ACCESS.
- Timeout: the counter increments each ACCESS cycle without mem_ack. On reaching TIMEOUT_CYCLES, drop mem_req and enter DONE with bus_error=1, rsp_rdata unchanged. mem_ack in the same cycle as the timeout wins: normal completion, bus_error=0.
- Misaligned: no bus cycle at all; rsp_valid one cycle after accept; misaligned=1; rsp_rdata unchanged.
- mem_ack while not in ACCESS is ignored.
- req_valid while busy is ignored (req_ready=0); the FSM must hold it.

Decomposition:
- Shared package holds:
  - mem_width_t enum (MEM_B=3'b000, MEM_H=001, MEM_W=010, MEM_BU=100, MEM_HU=101)
  - mau_state_t (IDLE, ACCESS, DONE)
  - data_t reused
- Sub-module load_extend: combinational, (mem_rdata, addr[1:0], funct3) -> 32-bit extended result. Verified standalone.

Test Plan:
- Word store: addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles -> mem_addr=0x100, mem_be=1111, mem_we=1, mem_wdata=0xDEADBEEF; mem_req high 3 cycles; rsp_valid one cycle later; misaligned=0.
- Byte loads: mem_rdata=0x80FF7F01, LB at addr 0x203 -> rsp_rdata=0xFFFFFF80, mem_be=1000. LBU at 0x203 -> 0x00000080. LB at 0x201 -> 0x0000007F.
- Half store/load: SH addr=0x32, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD. LH with mem_rdata=0x8001xxxx at 0x32 -> 0xFFFF8001.
- Misaligned: LW at 0x102 or SH at 0x101 -> no mem_req ever; rsp_valid 1 cycle after accept with misaligned=1. funct3=011 -> same result.
- Timeout: TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, then rsp_valid with bus_error=1. Repeat with ack on cycle 4 -> bus_error=0.
- Reset: reset=0 while in ACCESS -> next cycle mem_req=0, req_ready=1, no rsp_valid. Late mem_ack afterwards is ignored. A new request then completes normally.
